// File: rtl/iq_pkg.sv
// Shared definitions for the iq_subtractor_pipe slice: operation codes and the
// offset-binary <-> two's-complement conversion helpers.
package iq_pkg;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // Helpers work on a wide container; callers pass the live sample width.
  localparam int unsigned MAX_WIDTH = 256;
  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t ob2tc(input word_t x, input int unsigned w);
    return x ^ (word_t'(1) << (w - 1));
  endfunction

  function automatic word_t tc2ob(input word_t x, input int unsigned w);
    return x ^ (word_t'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/iq_lane_alu.sv
// Combinational single-lane add/sub in WIDTH+1 bits with overflow detection.
// Define SUB_SAT_EN to saturate overflowing results instead of wrapping.
module iq_lane_alu
  import iq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a_tc,
  input  logic [WIDTH-1:0] i_b_tc,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf
);

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res_tc;

  assign w_a_ext = {i_a_tc[WIDTH-1], i_a_tc};
  assign w_b_ext = {i_b_tc[WIDTH-1], i_b_tc};

  always_comb begin
    w_sum = w_a_ext - w_b_ext;
    if (i_mode == MODE_ADD) begin
      w_sum = w_a_ext + w_b_ext;
    end
  end

  assign o_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

`ifdef SUB_SAT_EN
  // Bit WIDTH carries the true sign of the unbounded result.
  always_comb begin
    w_res_tc = w_sum[WIDTH-1:0];
    if (o_ovf) begin
      w_res_tc = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res_tc = w_sum[WIDTH-1:0];
`endif

  assign o_result = WIDTH'(tc2ob(word_t'(w_res_tc), WIDTH));

endmodule

// File: rtl/iq_subtractor_pipe.sv
// NUM_CH-lane offset-binary add/sub with a two-stage valid/ready pipeline and
// sticky per-lane overflow flags. SUB_SAT_EN selects saturating results.
module iq_subtractor_pipe
  import iq_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 1
) (
  input  logic                    M100CLK,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic [NUM_CH*WIDTH-1:0] a,
  input  logic [NUM_CH*WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] result,
  output logic [NUM_CH-1:0]       ovf,
  input  logic                    clear_ovf
);

  localparam int unsigned BUS_W = NUM_CH * WIDTH;

  logic             r_s1_valid;
  logic             r_s1_mode;
  logic [BUS_W-1:0] r_s1_a;
  logic [BUS_W-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [BUS_W-1:0] r_result;
  logic [NUM_CH-1:0] r_ovf;

  logic              w_s1_load;
  logic              w_s2_load;
  logic              w_accept;
  logic [BUS_W-1:0]  w_a_tc;
  logic [BUS_W-1:0]  w_b_tc;
  logic [BUS_W-1:0]  w_alu_res;
  logic [NUM_CH-1:0] w_alu_ovf;
  logic [NUM_CH-1:0] w_ovf_set;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign w_a_tc[k*WIDTH +: WIDTH] = WIDTH'(ob2tc(word_t'(a[k*WIDTH +: WIDTH]), WIDTH));
    assign w_b_tc[k*WIDTH +: WIDTH] = WIDTH'(ob2tc(word_t'(b[k*WIDTH +: WIDTH]), WIDTH));

    iq_lane_alu #(
      .WIDTH(WIDTH)
    ) u_alu (
      .i_a_tc  (r_s1_a[k*WIDTH +: WIDTH]),
      .i_b_tc  (r_s1_b[k*WIDTH +: WIDTH]),
      .i_mode  (r_s1_mode),
      .o_result(w_alu_res[k*WIDTH +: WIDTH]),
      .o_ovf   (w_alu_ovf[k])
    );
  end

  // A set landing in the same cycle as clear_ovf must survive the clear.
  assign w_ovf_set = (w_s2_load && r_s1_valid) ? w_alu_ovf : '0;

  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_SUB;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode <= mode;
        r_s1_a    <= w_a_tc;
        r_s1_b    <= w_b_tc;
      end
    end
  end

  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_alu_res;
      end
    end
  end

  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (clear_ovf ? '0 : r_ovf) | w_ovf_set;
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_iq_subtractor_pipe.sv
// Directed self-checking bench for iq_subtractor_pipe (WIDTH=4, NUM_CH=2);
// expectations follow SUB_SAT_EN when it is defined.
module tb_iq_subtractor_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned N = 2;

`ifdef SUB_SAT_EN
  localparam logic [31:0] EXP_ADD_OVF = 32'h8F;
  localparam logic [31:0] EXP_SUB_OVF = 32'hFF;
`else
  localparam logic [31:0] EXP_ADD_OVF = 32'h80;
  localparam logic [31:0] EXP_SUB_OVF = 32'h07;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           mode;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] result;
  logic [N-1:0]   ovf;
  logic           clear_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iq_subtractor_pipe #(
    .WIDTH (W),
    .NUM_CH(N)
  ) dut (
    .M100CLK  (clk),
    .reset    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf),
    .clear_ovf(clear_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat for one cycle; returns just after the accepting edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vm);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    mode     = vm;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] bp_a   [6] = '{8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] bp_b   [6] = '{8'h89, 8'h99, 8'hA9, 8'hB9, 8'hC9, 8'hD9};
  logic [7:0] bp_exp [6] = '{8'h87, 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sent;
    int         got;
    int         cyc;
    int         first_acc;
    int         first_out;
    int         last_out;
    int         gaps;
    int         stale;
    bit         saw_stall;
    bit         prev_stalled;
    logic [7:0] prev_res;
    logic [3:0] nib;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    clear_ovf = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Basic subtract: lane0 +2-+7=-5, lane1 +1-0=+1
    send(8'h9A, 8'h8F, 1'b0);
    check("sub_latency_early", 32'(out_valid), 32'h0);
    tick();
    check("sub_valid", 32'(out_valid), 32'h1);
    check("sub_result", 32'(result), 32'h93);
    check("sub_ovf", 32'(ovf), 32'h0);

    // Add: +4+3=+7, then +4+4 overflows lane0
    send(8'h8C, 8'h8B, 1'b1);
    tick();
    check("add_result", 32'(result), 32'h8F);
    check("add_ovf", 32'(ovf), 32'h0);
    send(8'h8C, 8'h8C, 1'b1);
    tick();
    check("add_ovf_result", 32'(result), EXP_ADD_OVF);
    check("add_ovf_flag", 32'(ovf), 32'h1);
    tick();
    tick();
    check("ovf_sticky", 32'(ovf), 32'h1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_clear", 32'(ovf), 32'h0);

    // Subtract overflow: +7-(-8) on lane0, 0-(-8) on lane1
    send(8'h8F, 8'h00, 1'b0);
    tick();
    check("subovf_result", 32'(result), EXP_SUB_OVF);
    check("subovf_flag", 32'(ovf), 32'h3);

    // Clear coincides with a lane0 set: lane0 stays set, lane1 clears
    send(8'h8C, 8'h8C, 1'b1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_set_valid", 32'(out_valid), 32'h1);
    check("clr_set_ovf", 32'(ovf), 32'h1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_set_cleared", 32'(ovf), 32'h0);

    // Backpressure: out_ready low for cycles 3..5 of a 6-beat stream
    sent = 0;
    got = 0;
    cyc = 0;
    saw_stall = 1'b0;
    prev_stalled = 1'b0;
    prev_res = '0;
    while (got < 6 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        a    = bp_a[sent];
        b    = bp_b[sent];
        mode = 1'b0;
      end
      #1;
      if (prev_stalled) begin
        check("bp_hold_valid", 32'(out_valid), 32'h1);
        check("bp_hold_result", 32'(result), 32'(prev_res));
      end
      if (!out_ready && in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d", got), 32'(result), 32'(bp_exp[got]));
        got++;
      end
      prev_stalled = out_valid && !out_ready;
      prev_res = result;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(got), 32'd6);
    check("bp_in_ready_drop", 32'(saw_stall), 32'h1);
    #1;
    check("bp_no_dup", 32'(out_valid), 32'h0);
    tick();

    // Throughput: 16 back-to-back beats, a-0 returns a on both lanes
    sent = 0;
    got = 0;
    cyc = 0;
    first_acc = -1;
    first_out = -1;
    last_out = -1;
    gaps = 0;
    while (got < 16 && cyc < 60) begin
      out_ready = 1'b1;
      in_valid  = (sent < 16);
      nib       = sent[3:0];
      a         = {nib, nib};
      b         = 8'h88;
      mode      = 1'b0;
      #1;
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        else if (cyc != last_out + 1) gaps++;
        last_out = cyc;
        nib = got[3:0];
        check($sformatf("tp_out%0d", got), 32'(result), 32'({nib, nib}));
        got++;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("tp_count", 32'(got), 32'd16);
    check("tp_latency", 32'(first_out - first_acc), 32'd2);
    check("tp_gaps", 32'(gaps), 32'd0);
    tick();
    tick();

    // Reset with two beats in flight (one of them overflowing)
    out_ready = 1'b0;
    send(8'h8C, 8'h8C, 1'b1);
    send(8'h9A, 8'h8F, 1'b0);
    check("rstmid_pre_valid", 32'(out_valid), 32'h1);
    check("rstmid_pre_ovf", 32'(ovf), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'h0);
    check("rstmid_result", 32'(result), 32'h0);
    check("rstmid_ovf", 32'(ovf), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale++;
    end
    check("rstmid_no_stale", 32'(stale), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
